guess_round_ctrl: RTL and testbench

//  Clocked round controller for the two-player guess-number game. It shares one set of four

---
 rtl/guess_pkg.sv | 19 +
 rtl/btn_edge.sv | 36 +++
 rtl/guess_round_ctrl.sv | 128 ++++++++++++
 tb/tb_guess_round_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/guess_pkg.sv
// Shared types and constants for the guess-number round controller.
package guess_pkg;

  typedef enum logic [2:0] {
    SET   = 3'd0,
    GUESS = 3'd1,
    CMP   = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } phase_t;

  localparam int SYM_W = 2;

  localparam logic [SYM_W-1:0] SYM_I1 = 2'd0;
  localparam logic [SYM_W-1:0] SYM_I2 = 2'd1;
  localparam logic [SYM_W-1:0] SYM_I3 = 2'd2;
  localparam logic [SYM_W-1:0] SYM_I4 = 2'd3;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detect for the four symbol buttons and enter, with I1>I2>I3>I4 priority.
module btn_edge
  import guess_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       syms,
  input  logic             enter,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym,
  output logic             enter_pulse
);

  logic [4:0] prev;
  logic [4:0] rise;

  // Loading 1 on reset means a button held through reset needs a release first.
  always_ff @(posedge clk) begin
    if (reset) prev <= '1;
    else       prev <= {enter, syms};
  end

  assign rise = {enter, syms} & ~prev;

  always_comb begin
    sym_valid = |rise[3:0];
    sym       = SYM_I1;
    if      (rise[0]) sym = SYM_I1;
    else if (rise[1]) sym = SYM_I2;
    else if (rise[2]) sym = SYM_I3;
    else if (rise[3]) sym = SYM_I4;
  end

  assign enter_pulse = rise[4] & ~sym_valid;

endmodule

// File: rtl/guess_round_ctrl.sv
// Round sequencer: collects secret and guess, compares, counts turns, drives result flags.
module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter int MIN_LEN   = 4,
  parameter int MAX_LEN   = 7,
  parameter int MAX_TURNS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               I1,
  input  logic               I2,
  input  logic               I3,
  input  logic               I4,
  input  logic               enter,
  output logic [2:0]         phase,
  output logic [3:0]         numa,
  output logic [3:0]         numb,
  output logic [1:0]         turn,
  output logic [MAX_LEN-1:0] match_mask,
  output logic               result_valid,
  output logic               win,
  output logic               lose,
  output logic               equal,
  output logic               bigger,
  output logic               smaller
);

  localparam logic [3:0] MAX_L = 4'(MAX_LEN);
  localparam logic [3:0] MIN_L = 4'(MIN_LEN);
  localparam logic [1:0] MAX_T = 2'(MAX_TURNS);

  phase_t                             state;
  logic [MAX_LEN-1:0][SYM_W-1:0]      secret, guess;
  logic                               sym_valid, enter_pulse;
  logic [SYM_W-1:0]                   sym;
  logic [MAX_LEN-1:0]                 mm_c, len_c;
  logic                               win_c;

  btn_edge u_btn (
    .clk         (clk),
    .reset       (reset),
    .syms        ({I4, I3, I2, I1}),
    .enter       (enter),
    .sym_valid   (sym_valid),
    .sym         (sym),
    .enter_pulse (enter_pulse)
  );

  // Only positions held by both sequences can match; win needs every secret position matched.
  always_comb begin
    mm_c  = '0;
    len_c = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_c[i] = 4'(i) < numa;
      mm_c[i]  = (4'(i) < numa) && (4'(i) < numb) && (secret[i] == guess[i]);
    end
    win_c = (numa == numb) && (mm_c == len_c);
  end

  assign phase = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SET;
      numa         <= '0;
      numb         <= '0;
      turn         <= '0;
      secret       <= '0;
      guess        <= '0;
      match_mask   <= '0;
      result_valid <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
      equal        <= 1'b0;
      bigger       <= 1'b0;
      smaller      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        SET: begin
          if (sym_valid) begin
            for (int i = 0; i < MAX_LEN; i++)
              if (4'(i) == numa) secret[i] <= sym;
            numa <= numa + 4'd1;
            if (numa + 4'd1 == MAX_L) state <= GUESS;
          end else if (enter_pulse && numa >= MIN_L) begin
            state <= GUESS;
          end
        end
        GUESS: begin
          if (sym_valid) begin
            if (numb < MAX_L) begin
              for (int i = 0; i < MAX_LEN; i++)
                if (4'(i) == numb) guess[i] <= sym;
              numb <= numb + 4'd1;
            end
          end else if (enter_pulse && numb >= MIN_L) begin
            state <= CMP;
          end
        end
        CMP: begin
          match_mask   <= mm_c;
          result_valid <= 1'b1;
          smaller      <= numb > numa;
          equal        <= numb == numa;
          bigger       <= numb < numa;
          if (win_c) begin
            win   <= 1'b1;
            state <= WIN;
          end else begin
            turn <= turn + 2'd1;
            if (turn + 2'd1 == MAX_T) begin
              lose  <= 1'b1;
              state <= LOSE;
            end else begin
              numb  <= '0;
              guess <= '0;
              state <= GUESS;
            end
          end
        end
        default: ;  // WIN and LOSE hold everything until reset
      endcase
    end
  end

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for guess_round_ctrl with a result scoreboard checked on result_valid.
module tb_guess_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       I1, I2, I3, I4, enter;
  logic [2:0] phase;
  logic [3:0] numa, numb;
  logic [1:0] turn;
  logic [6:0] match_mask;
  logic       result_valid, win, lose, equal, bigger, smaller;

  int tests = 0;
  int fails = 0;

  // expected result packed as {match_mask, win, lose, equal, bigger, smaller, turn}
  logic [13:0] sb[$];

  guess_round_ctrl #(.MIN_LEN(4), .MAX_LEN(7), .MAX_TURNS(3)) dut (
    .clk(clk), .reset(reset), .I1(I1), .I2(I2), .I3(I3), .I4(I4), .enter(enter),
    .phase(phase), .numa(numa), .numb(numb), .turn(turn), .match_mask(match_mask),
    .result_valid(result_valid), .win(win), .lose(lose), .equal(equal),
    .bigger(bigger), .smaller(smaller)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (result_valid) begin
      logic [13:0] act, exp_v;
      act = {match_mask, win, lose, equal, bigger, smaller, turn};
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL result_unexpected got=%h want=none", act);
      end else begin
        exp_v = sb.pop_front();
        if (act !== exp_v) begin
          fails++;
          $display("FAIL result got=%h want=%h", act, exp_v);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] b);
    {enter, I4, I3, I2, I1} = b;
  endtask

  // press and release; k=0..3 symbols, k=4 enter
  task automatic press(input int k);
    logic [4:0] b;
    b = '0;
    b[k] = 1'b1;
    drive(b);
    tick();
    drive('0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive('0);
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic enter_cmp(input logic [13:0] exp_v, input logic [2:0] next_ph);
    sb.push_back(exp_v);
    drive(5'b10000);
    tick();
    check("phase_cmp", 32'(phase), 32'd2);
    drive('0);
    tick();
    check("result_valid", 32'(result_valid), 32'd1);
    check("phase_after_cmp", 32'(phase), 32'(next_ph));
    tick();
    check("result_valid_pulse", 32'(result_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive('0);
    tick();
    tick();
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_counts", {20'd0, numa, numb, turn, 2'd0}, 32'd0);
    check("rst_flags", {22'd0, match_mask, result_valid, win, lose, equal, bigger, smaller} , 32'd0);
    reset = 1'b0;
    tick();

    // exact match win
    for (int i = 0; i < 4; i++) press(i);
    press(4);
    check("t1_numa", 32'(numa), 32'd4);
    check("t1_phase_guess", 32'(phase), 32'd1);
    for (int i = 0; i < 4; i++) press(i);
    enter_cmp({7'b0001111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}, 3'd3);
    press(0);
    check("t1_win_hold_numb", 32'(numb), 32'd4);
    check("t1_win_hold_phase", 32'(phase), 32'd3);

    // three wrong guesses -> lose
    do_reset();
    for (int i = 0; i < 4; i++) press(i);
    press(4);
    for (int t = 1; t <= 3; t++) begin
      for (int i = 0; i < 4; i++) press(3);
      enter_cmp({7'b0001000, 1'b0, t == 3, 1'b1, 1'b0, 1'b0, 2'(t)}, t == 3 ? 3'd4 : 3'd1);
      check("t2_turn", 32'(turn), 32'(t));
      if (t < 3) check("t2_numb_clr", 32'(numb), 32'd0);
    end
    press(0);
    press(4);
    check("t2_lose_phase", 32'(phase), 32'd4);
    check("t2_lose_hold", {24'd0, numb, 1'b0, lose, turn}, {24'd0, 4'd4, 1'b0, 1'b1, 2'd3});

    // shorter guess than secret
    do_reset();
    for (int i = 0; i < 4; i++) press(i);
    press(0);
    press(4);
    check("t3_numa", 32'(numa), 32'd5);
    for (int i = 0; i < 4; i++) press(i);
    enter_cmp({7'b0001111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1}, 3'd1);
    check("t3_numb", 32'(numb), 32'd0);
    check("t3_turn", 32'(turn), 32'd1);

    // short enter ignored, auto-advance at MAX_LEN
    do_reset();
    for (int i = 0; i < 3; i++) press(i);
    press(4);
    check("t4_short_enter", 32'(phase), 32'd0);
    for (int i = 0; i < 3; i++) press(i);
    check("t4_six", 32'(phase), 32'd0);
    press(3);
    check("t4_auto_phase", 32'(phase), 32'd1);
    check("t4_numa7", 32'(numa), 32'd7);
    press(1);
    check("t4_8th_numb", 32'(numb), 32'd1);
    check("t4_8th_numa", 32'(numa), 32'd7);

    // priority, held button, symbol with enter
    do_reset();
    drive(5'b00101);
    tick();
    drive('0);
    tick();
    check("t5_prio_numa", 32'(numa), 32'd1);
    drive(5'b00010);
    for (int i = 0; i < 10; i++) tick();
    drive('0);
    tick();
    check("t5_held_numa", 32'(numa), 32'd2);
    drive(5'b10100);
    tick();
    drive('0);
    tick();
    check("t5_sym_enter_numa", 32'(numa), 32'd3);
    check("t5_sym_enter_phase", 32'(phase), 32'd0);
    press(3);
    press(4);
    for (int i = 0; i < 4; i++) press(i);
    enter_cmp({7'b0001111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0}, 3'd3);

    // reset mid-guess with I4 held
    do_reset();
    for (int i = 0; i < 4; i++) press(i);
    press(4);
    press(0);
    press(1);
    check("t6_numb2", 32'(numb), 32'd2);
    drive(5'b01000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_phase", 32'(phase), 32'd0);
    check("t6_zero", {16'd0, numa, numb, turn, win, lose, equal, bigger, smaller, result_valid},
          32'd0);
    check("t6_mask", 32'(match_mask), 32'd0);
    tick();
    tick();
    check("t6_held_ignored", 32'(numa), 32'd0);
    drive('0);
    tick();
    press(3);
    check("t6_repress", 32'(numa), 32'd1);

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
